sprite_anim_seq: RTL and testbench

Parametrised per-fighter animation sequencer. Replaces fixed stand/breathe/walk counters with a four-mode state machine: looping idle and walk, one-shot attack, and preemptive hit-stun. It also provides a hysteretic rage flag. It runs in the `vga_clk` domain and advances only on `vsync` rising edges. Its `anim_mode`, `frame_idx` and `rage` outputs drive the sprite-ROM colour mux that feeds the VGA pixel path.

---
 rtl/sprite_anim_seq_if.sv | 27 ++
 rtl/sprite_anim_seq.sv | 149 ++++++++++++++
 tb/tb_sprite_anim_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_seq_if.sv
// Bus bundle between the fighter control logic and the animation sequencer.
// The master drives motion, requests and health; the slave returns the sprite selection.
interface sprite_anim_seq_if #(
  parameter int HEALTH_W = 8,
  parameter int FRAME_W  = 2
);
  logic                vsync;
  logic [9:0]          motionx;
  logic                attack_req;
  logic                hit_req;
  logic [HEALTH_W-1:0] health;
  logic [1:0]          anim_mode;
  logic [FRAME_W-1:0]  frame_idx;
  logic                rage;
  logic                busy;
  logic                done;

  modport master (
    output vsync, motionx, attack_req, hit_req, health,
    input  anim_mode, frame_idx, rage, busy, done
  );

  modport slave (
    input  vsync, motionx, attack_req, hit_req, health,
    output anim_mode, frame_idx, rage, busy, done
  );
endinterface

// File: rtl/sprite_anim_seq.sv
// Per-fighter sprite animation sequencer: idle/walk loops, one-shot attack and
// preemptive hit-stun, stepped once per vsync rising edge, plus a hysteretic rage flag.
module sprite_anim_seq #(
  parameter int MAX_FRAMES  = 4,
  parameter int FRAME_W     = $clog2(MAX_FRAMES),
  parameter int HOLD_W      = 6,
  parameter int IDLE_FRAMES = 2,
  parameter int IDLE_HOLD   = 12,
  parameter int WALK_FRAMES = 4,
  parameter int WALK_HOLD   = 6,
  parameter int ATK_FRAMES  = 3,
  parameter int ATK_HOLD    = 4,
  parameter int HIT_FRAMES  = 2,
  parameter int HIT_HOLD    = 8,
  parameter int HEALTH_W    = 8,
  parameter int RAGE_ON     = 120,
  parameter int RAGE_OFF    = 100
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  sprite_anim_seq_if.slave       bus
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_ATTACK = 2'd2,
    MODE_HIT    = 2'd3
  } mode_t;

  mode_t               mode;
  logic [FRAME_W-1:0]  frame_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                vsync_q;
  logic                atk_pend;
  logic                hit_pend;
  logic                rage_q;
  logic                busy_q;
  logic                done_q;

  logic                tick;
  logic                atk_eff;
  logic                hit_eff;
  logic                at_hold_end;
  logic                at_last_frame;
  mode_t               rest_mode;
  mode_t               next_mode;
  logic [FRAME_W-1:0]  next_frame;
  logic [HOLD_W-1:0]   next_hold;
  logic                next_done;

  function automatic logic [FRAME_W-1:0] last_frame(input mode_t m);
    case (m)
      MODE_IDLE:   last_frame = FRAME_W'(IDLE_FRAMES - 1);
      MODE_WALK:   last_frame = FRAME_W'(WALK_FRAMES - 1);
      MODE_ATTACK: last_frame = FRAME_W'(ATK_FRAMES - 1);
      default:     last_frame = FRAME_W'(HIT_FRAMES - 1);
    endcase
  endfunction

  function automatic logic [HOLD_W-1:0] last_hold(input mode_t m);
    case (m)
      MODE_IDLE:   last_hold = HOLD_W'(IDLE_HOLD - 1);
      MODE_WALK:   last_hold = HOLD_W'(WALK_HOLD - 1);
      MODE_ATTACK: last_hold = HOLD_W'(ATK_HOLD - 1);
      default:     last_hold = HOLD_W'(HIT_HOLD - 1);
    endcase
  endfunction

  // Next-state datapath, only committed on tick cycles.
  always_comb begin
    tick          = bus.vsync & ~vsync_q;
    atk_eff       = atk_pend | bus.attack_req;
    hit_eff       = hit_pend | bus.hit_req;
    rest_mode     = (bus.motionx != '0) ? MODE_WALK : MODE_IDLE;
    at_hold_end   = (hold_cnt == last_hold(mode));
    at_last_frame = (frame_q == last_frame(mode));
    next_frame    = frame_q;
    next_hold     = hold_cnt;
    next_done     = 1'b0;

    if (hit_eff)
      next_mode = MODE_HIT;
    else if (mode == MODE_ATTACK || mode == MODE_HIT)
      next_mode = mode;
    else if (atk_eff)
      next_mode = MODE_ATTACK;
    else
      next_mode = rest_mode;

    // A hit always restarts from frame 0, even when already stunned.
    if (hit_eff || next_mode != mode) begin
      next_frame = '0;
      next_hold  = '0;
    end else if (!at_hold_end) begin
      next_hold = hold_cnt + HOLD_W'(1);
    end else begin
      next_hold = '0;
      if (!at_last_frame) begin
        next_frame = frame_q + FRAME_W'(1);
      end else if (mode == MODE_ATTACK || mode == MODE_HIT) begin
        next_mode  = rest_mode;
        next_frame = '0;
        next_done  = 1'b1;
      end else begin
        next_frame = '0;
      end
    end
  end

  // vsync_q keeps following vsync through reset so a strobe already high at
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge vga_clk) begin
    vsync_q <= bus.vsync;
    if (reset) begin
      mode     <= MODE_IDLE;
      frame_q  <= '0;
      hold_cnt <= '0;
      atk_pend <= 1'b0;
      hit_pend <= 1'b0;
      rage_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (tick) begin
      mode     <= next_mode;
      frame_q  <= next_frame;
      hold_cnt <= next_hold;
      atk_pend <= 1'b0;
      hit_pend <= 1'b0;
      done_q   <= next_done;
      busy_q   <= (next_mode == MODE_ATTACK) || (next_mode == MODE_HIT);
      if (bus.health >= HEALTH_W'(RAGE_ON))
        rage_q <= 1'b1;
      else if (bus.health < HEALTH_W'(RAGE_OFF))
        rage_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.attack_req) atk_pend <= 1'b1;
      if (bus.hit_req)    hit_pend <= 1'b1;
    end
  end

  assign bus.anim_mode = mode;
  assign bus.frame_idx = frame_q;
  assign bus.rage      = rage_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq: a table of tick groups with hand-computed
// expectations, followed by hand-written corner sequences around requests and reset.
module tb_sprite_anim_seq;

  logic vga_clk;
  logic reset;

  sprite_anim_seq_if #(.HEALTH_W(8), .FRAME_W(2)) bus ();

  sprite_anim_seq dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  typedef struct {
    int   n;
    int   motionx;
    bit   atk;
    bit   hit;
    int   health;
    int   mode;
    int   frame;
    bit   rage;
    bit   busy;
    bit   done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;
  int   s_mode;
  int   s_frame;
  int   s_rage;
  int   s_busy;
  int   s_done;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input int n, input int mx, input bit atk, input bit hit,
                                  input int hl, input int m, input int f, input bit r,
                                  input bit b, input bit d);
    vec_t v;
    v.n = n; v.motionx = mx; v.atk = atk; v.hit = hit; v.health = hl;
    v.mode = m; v.frame = f; v.rage = r; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // One vsync strobe; requests passed in land in the tick cycle itself.
  task automatic do_tick(input bit atk, input bit hit);
    bus.vsync      = 1'b1;
    bus.attack_req = atk;
    bus.hit_req    = hit;
    @(negedge vga_clk);
    bus.attack_req = 1'b0;
    bus.hit_req    = 1'b0;
    s_mode  = int'(bus.anim_mode);
    s_frame = int'(bus.frame_idx);
    s_rage  = int'(bus.rage);
    s_busy  = int'(bus.busy);
    s_done  = int'(bus.done);
    bus.vsync = 1'b0;
    @(negedge vga_clk);
    check_output("done_one_cycle", int'(bus.done), 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.motionx = v.motionx[9:0];
    bus.health  = v.health[7:0];
    if (v.atk || v.hit) begin
      bus.attack_req = v.atk;
      bus.hit_req    = v.hit;
      @(negedge vga_clk);
      bus.attack_req = 1'b0;
      bus.hit_req    = 1'b0;
    end
    repeat (v.n) do_tick(1'b0, 1'b0);
  endtask

  task automatic check_snapshot(input string tag, input int m, input int f, input int r,
                                input int b, input int d);
    check_output({tag, " mode"},  s_mode,  m);
    check_output({tag, " frame"}, s_frame, f);
    check_output({tag, " rage"},  s_rage,  r);
    check_output({tag, " busy"},  s_busy,  b);
    check_output({tag, " done"},  s_done,  d);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.vsync      = 1'b0;
    bus.motionx    = '0;
    bus.attack_req = 1'b0;
    bus.hit_req    = 1'b0;
    bus.health     = '0;

    // Idle loop: frame 0 for 12 ticks, 1 for 12, back to 0.
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(11, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Walk loop in 6-tick runs, then stop mid-frame.
    add_vec( 1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec( 5, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec( 1, 5, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec( 6, 5, 0, 0, 0, 1, 2, 0, 0, 0);
    add_vec( 6, 5, 0, 0, 0, 1, 3, 0, 0, 0);
    add_vec( 6, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec( 3, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Attack from idle with an ignored retrigger, exit on the 12th tick.
    add_vec( 1, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    add_vec( 3, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    add_vec( 1, 0, 0, 0, 0, 2, 1, 0, 1, 0);
    add_vec( 3, 0, 1, 0, 0, 2, 1, 0, 1, 0);
    add_vec( 1, 0, 0, 0, 0, 2, 2, 0, 1, 0);
    add_vec( 3, 0, 0, 0, 0, 2, 2, 0, 1, 0);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Hit and attack together in attack frame 1: hit wins, 16-tick stun.
    add_vec( 1, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    add_vec( 4, 0, 0, 0, 0, 2, 1, 0, 1, 0);
    add_vec( 1, 0, 1, 1, 0, 3, 0, 0, 1, 0);
    add_vec(15, 0, 0, 0, 0, 3, 1, 0, 1, 0);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_vec( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Rage hysteresis sweep, including both exact thresholds.
    add_vec( 1, 0, 0, 0, 130, 0, 0, 1, 0, 0);
    add_vec( 1, 0, 0, 0, 110, 0, 0, 1, 0, 0);
    add_vec( 1, 0, 0, 0,  99, 0, 0, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 110, 0, 0, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 125, 0, 0, 1, 0, 0);
    add_vec( 1, 0, 0, 0, 100, 0, 0, 1, 0, 0);
    add_vec( 1, 0, 0, 0,  99, 0, 0, 0, 0, 0);
    add_vec( 1, 0, 0, 0, 120, 0, 0, 1, 0, 0);

    repeat (3) @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
    check_output("reset mode",  int'(bus.anim_mode), 0);
    check_output("reset frame", int'(bus.frame_idx), 0);
    check_output("reset rage",  int'(bus.rage), 0);
    check_output("reset busy",  int'(bus.busy), 0);
    check_output("reset done",  int'(bus.done), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_snapshot($sformatf("vec%0d", i), vecs[i].mode, vecs[i].frame,
                     int'(vecs[i].rage), int'(vecs[i].busy), int'(vecs[i].done));
    end

    // Rage must not move between ticks.
    bus.health = 8'd0;
    repeat (3) @(negedge vga_clk);
    check_output("rage_between_ticks", int'(bus.rage), 1);
    do_tick(1'b0, 1'b0);
    check_output("rage_at_tick", s_rage, 0);

    // Requests arriving in the tick cycle itself; hit restarts an ongoing stun.
    do_tick(1'b1, 1'b0);
    check_snapshot("atk_in_tick", 2, 0, 0, 1, 0);
    repeat (3) do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b1);
    check_snapshot("hit_in_tick", 3, 0, 0, 1, 0);
    repeat (9) do_tick(1'b0, 1'b0);
    check_snapshot("hit_frame1", 3, 1, 0, 1, 0);
    do_tick(1'b0, 1'b1);
    check_snapshot("hit_restart", 3, 0, 0, 1, 0);
    repeat (8) do_tick(1'b0, 1'b0);
    check_snapshot("restart_frame1", 3, 1, 0, 1, 0);
    repeat (7) do_tick(1'b0, 1'b0);
    bus.motionx = 10'd3;
    do_tick(1'b0, 1'b0);
    check_snapshot("hit_exit_walk", 1, 0, 0, 0, 1);

    // Reset mid-hit, coincident with a tick and an attack request.
    bus.health = 8'd130;
    bus.motionx = 10'd0;
    do_tick(1'b0, 1'b1);
    check_snapshot("pre_reset_hit", 3, 0, 1, 1, 0);
    repeat (2) do_tick(1'b0, 1'b0);
    reset          = 1'b1;
    bus.vsync      = 1'b1;
    bus.attack_req = 1'b1;
    @(negedge vga_clk);
    bus.attack_req = 1'b0;
    check_output("mid_reset mode",  int'(bus.anim_mode), 0);
    check_output("mid_reset frame", int'(bus.frame_idx), 0);
    check_output("mid_reset rage",  int'(bus.rage), 0);
    check_output("mid_reset busy",  int'(bus.busy), 0);
    check_output("mid_reset done",  int'(bus.done), 0);
    bus.motionx = 10'd5;
    @(negedge vga_clk);
    reset = 1'b0;
    repeat (3) @(negedge vga_clk);
    check_output("no_tick_after_reset mode", int'(bus.anim_mode), 0);
    bus.vsync   = 1'b0;
    bus.motionx = 10'd0;
    @(negedge vga_clk);
    do_tick(1'b0, 1'b0);
    check_snapshot("post_reset_tick", 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
